// File: rtl/uart_tx_buffer_pkg.sv
// rtl/uart_tx_buffer_pkg.sv - shared state encodings and default timing for the UART transmit buffer
package uart_tx_buffer_pkg;

   typedef enum logic [2:0] {
      UTX_IDLE      = 3'd0,
      UTX_SETUP     = 3'd1,
      UTX_STROBE    = 3'd2,
      UTX_WAIT_TBRE = 3'd3,
      UTX_WAIT_TSRE = 3'd4
   } utx_state_e;

   localparam int UTX_SETUP_CYCLES_DEF  = 2;
   localparam int UTX_STROBE_CYCLES_DEF = 4;

endpackage

// File: rtl/utx_fifo.sv
// rtl/utx_fifo.sv - parameterised synchronous byte FIFO with occupancy count
module utx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    wr_data,
   output logic [7:0]    rd_data,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - buffers CPU serial-port stores and drains them over the UART wrn/tbre/tsre handshake
module uart_tx_buffer
   import uart_tx_buffer_pkg::*;
#(
   parameter int DEPTH         = 16,
   parameter int AW            = 4,
   parameter int SETUP_CYCLES  = UTX_SETUP_CYCLES_DEF,
   parameter int STROBE_CYCLES = UTX_STROBE_CYCLES_DEF
) (
   input  logic          utxi_clk,
   input  logic          utxi_rst,
   input  logic          utxi_wrn,
   input  logic [7:0]    utxi_data,
   input  logic          utxi_bus_grant,
   input  logic          utxi_tbre,
   input  logic          utxi_tsre,
   output logic          utxo_bus_req,
   output logic          utxo_bus_oe,
   output logic [7:0]    utxo_bus_data,
   output logic          utxo_uart_wrn,
   output logic          utxo_writeable,
   output logic [AW:0]   utxo_level,
   output logic          utxo_idle,
   output logic          utxo_overflow,
   input  logic          utxi_ovf_clr
);

   localparam logic [AW+2:0] SETUP_LOAD  = (AW+3)'(SETUP_CYCLES - 1);
   localparam logic [AW+2:0] STROBE_LOAD = (AW+3)'(STROBE_CYCLES - 1);

   utx_state_e    state_q, state_d;
   logic [AW+2:0] cnt_q, cnt_d;
   logic          prev_wrn_q;
   logic          push_q;
   logic [7:0]    push_data_q;
   logic          pop;
   logic          req_d, oe_d, wrn_d;
   logic [7:0]    fifo_rd_data;
   logic          fifo_full, fifo_empty;

   utx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk     (utxi_clk),
      .rst     (utxi_rst),
      .push    (push_q),
      .pop     (pop),
      .wr_data (push_data_q),
      .rd_data (fifo_rd_data),
      .level   (utxo_level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign utxo_writeable = !fifo_full;
   assign utxo_idle      = fifo_empty && (state_q == UTX_IDLE);

   // Outputs are decoded from the next state so they leave the flops aligned with it
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      req_d   = 1'b0;
      oe_d    = 1'b0;
      wrn_d   = 1'b1;
      case (state_q)
         UTX_IDLE: begin
            req_d = !fifo_empty || push_q;
            if (utxo_bus_req && utxi_bus_grant && !fifo_empty) begin
               pop     = 1'b1;
               state_d = UTX_SETUP;
               cnt_d   = SETUP_LOAD;
               req_d   = 1'b1;
               oe_d    = 1'b1;
            end
         end
         UTX_SETUP: begin
            req_d = 1'b1;
            oe_d  = 1'b1;
            if (cnt_q == '0) begin
               state_d = UTX_STROBE;
               cnt_d   = STROBE_LOAD;
               wrn_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         UTX_STROBE: begin
            if (cnt_q == '0) begin
               state_d = UTX_WAIT_TBRE;
            end else begin
               req_d = 1'b1;
               oe_d  = 1'b1;
               wrn_d = 1'b0;
               cnt_d = cnt_q - 1'b1;
            end
         end
         UTX_WAIT_TBRE: begin
            if (utxi_tbre) begin
               state_d = UTX_WAIT_TSRE;
            end
         end
         UTX_WAIT_TSRE: begin
            if (utxi_tsre) begin
               state_d = UTX_IDLE;
            end
         end
         default: state_d = UTX_IDLE;
      endcase
   end

   always_ff @(posedge utxi_clk) begin
      if (utxi_rst) begin
         state_q       <= UTX_IDLE;
         cnt_q         <= '0;
         prev_wrn_q    <= 1'b1;
         push_q        <= 1'b0;
         push_data_q   <= '0;
         utxo_bus_req  <= 1'b0;
         utxo_bus_oe   <= 1'b0;
         utxo_uart_wrn <= 1'b1;
         utxo_bus_data <= '0;
         utxo_overflow <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         prev_wrn_q    <= utxi_wrn;
         push_q        <= !utxi_wrn && prev_wrn_q;
         push_data_q   <= utxi_data;
         utxo_bus_req  <= req_d;
         utxo_bus_oe   <= oe_d;
         utxo_uart_wrn <= wrn_d;
         if (pop) begin
            utxo_bus_data <= fifo_rd_data;
         end
         // A dropped push outranks a simultaneous clear
         if (push_q && fifo_full && !pop) begin
            utxo_overflow <= 1'b1;
         end else if (utxi_ovf_clr) begin
            utxo_overflow <= 1'b0;
         end
      end
   end

endmodule
